// File: rtl/bitop_dec_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bitop_dec_pkg : shared types and constants for bitop_decoder         |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
package bitop_dec_pkg;

   localparam int C_DATA_W = 8;
   localparam int C_CNT_W  = 16;

   localparam logic [C_CNT_W-1:0] C_CNT_MAX = '1;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_AND   = 2'b01,
      OP_OR    = 2'b10,
      OP_AMBIG = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CAPT = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Saturating increment: a counter at full scale stays there.
   function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v);
      return (v == C_CNT_MAX) ? v : v + C_CNT_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bitop_classify.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bitop_classify : decides whether result came from a&b, a|b, both   |
// |                  (a==b) or neither                                  |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module bitop_classify
   import bitop_dec_pkg::*;
(
   input  logic [C_DATA_W-1:0] a,
   input  logic [C_DATA_W-1:0] b,
   input  logic [C_DATA_W-1:0] result,
   output logic [1:0]          op_code
);

   logic w_is_and;
   logic w_is_or;

   assign w_is_and = (result == (a & b));
   assign w_is_or  = (result == (a | b));

   always_comb begin
      op_code = OP_NONE;
      case ({w_is_and, w_is_or})
         2'b11:   op_code = OP_AMBIG;
         2'b10:   op_code = OP_AND;
         2'b01:   op_code = OP_OR;
         default: op_code = OP_NONE;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/bitop_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bitop_decoder : recovers the AND/OR select from observed triples,  |
// |                 optional statistics under BITOP_DEC_STATS_EN        |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
module bitop_decoder
   import bitop_dec_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [C_DATA_W-1:0] a,
   input  logic [C_DATA_W-1:0] b,
   input  logic [C_DATA_W-1:0] result,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [1:0]          op_code,
   output logic                x_rec,
   output logic                err,
   input  logic                stats_clr,
   output logic [C_CNT_W-1:0]  and_cnt,
   output logic [C_CNT_W-1:0]  or_cnt,
   output logic [C_CNT_W-1:0]  err_cnt
);

   state_e              r_state;
   state_e              w_state_nxt;

   logic                r_in_ready;
   logic                r_out_valid;
   logic [1:0]          r_op_code;
   logic                r_x_rec;
   logic                r_err;

   logic [C_DATA_W-1:0] r_a;
   logic [C_DATA_W-1:0] r_b;
   logic [C_DATA_W-1:0] r_result;

   logic [1:0]          w_class_op;
   logic                w_accept;
   logic                w_handshake;
   logic                w_in_ready_nxt;
   logic                w_out_valid_nxt;
   logic                w_load_class;

   assign w_accept    = in_valid & r_in_ready;
   assign w_handshake = r_out_valid & out_ready;

   // in_ready is a flop so it stays low during reset and rises one edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)    w_state_nxt = ST_CAPT;
         ST_CAPT:                  w_state_nxt = ST_DONE;
         ST_DONE: if (w_handshake) w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
      w_out_valid_nxt = (w_state_nxt == ST_DONE);
      w_load_class    = (r_state == ST_CAPT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_op_code   <= OP_NONE;
         r_x_rec     <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         if (w_load_class) begin
            r_op_code <= w_class_op;
            r_x_rec   <= (w_class_op == OP_AND) || (w_class_op == OP_AMBIG);
            r_err     <= (w_class_op == OP_NONE);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_a      <= a;
         r_b      <= b;
         r_result <= result;
      end
   end

   bitop_classify u_classify (
      .a       (r_a),
      .b       (r_b),
      .result  (r_result),
      .op_code (w_class_op)
   );

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign op_code   = r_op_code;
   assign x_rec     = r_x_rec;
   assign err       = r_err;

`ifdef BITOP_DEC_STATS_EN
   logic [C_CNT_W-1:0] r_and_cnt;
   logic [C_CNT_W-1:0] r_or_cnt;
   logic [C_CNT_W-1:0] r_err_cnt;

   // Clear wins over a same-cycle handshake increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_and_cnt <= '0;
         r_or_cnt  <= '0;
         r_err_cnt <= '0;
      end else if (stats_clr) begin
         r_and_cnt <= '0;
         r_or_cnt  <= '0;
         r_err_cnt <= '0;
      end else if (w_handshake) begin
         case (r_op_code)
            OP_AND, OP_AMBIG: r_and_cnt <= sat_inc(r_and_cnt);
            OP_OR:            r_or_cnt  <= sat_inc(r_or_cnt);
            default:          r_err_cnt <= sat_inc(r_err_cnt);
         endcase
      end
   end

   assign and_cnt = r_and_cnt;
   assign or_cnt  = r_or_cnt;
   assign err_cnt = r_err_cnt;
`else
   logic w_unused_stats_clr;
   assign w_unused_stats_clr = stats_clr;

   assign and_cnt = '0;
   assign or_cnt  = '0;
   assign err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitop_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bitop_decoder : scoreboard bench with directed triples           |
// | Revision         : 1.0                                              |
// +--------------------------------------------------------------------+
module tb_bitop_decoder;

   localparam logic [1:0] C_NONE  = 2'b00;
   localparam logic [1:0] C_AND   = 2'b01;
   localparam logic [1:0] C_OR    = 2'b10;
   localparam logic [1:0] C_AMBIG = 2'b11;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic        stats_clr = 1'b0;
   logic [7:0]  a         = 8'h00;
   logic [7:0]  b         = 8'h00;
   logic [7:0]  result    = 8'h00;
   logic        in_ready;
   logic        out_valid;
   logic [1:0]  op_code;
   logic        x_rec;
   logic        err;
   logic [15:0] and_cnt;
   logic [15:0] or_cnt;
   logic [15:0] err_cnt;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [1:0]  sb_q[$];
   int          acc_q[$];
   logic [15:0] m_and = 16'h0;
   logic [15:0] m_or  = 16'h0;
   logic [15:0] m_err = 16'h0;
   logic        r_prev_ov = 1'b0;

   bitop_decoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .result    (result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .op_code   (op_code),
      .x_rec     (x_rec),
      .err       (err),
      .stats_clr (stats_clr),
      .and_cnt   (and_cnt),
      .or_cnt    (or_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
   endtask

   function automatic logic [15:0] inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'h1;
   endfunction

   // Monitor / scoreboard: sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         r_prev_ov = 1'b0;
         m_and = 16'h0; m_or = 16'h0; m_err = 16'h0;
      end else begin
`ifdef BITOP_DEC_STATS_EN
         chk("and_cnt", and_cnt, m_and);
         chk("or_cnt",  or_cnt,  m_or);
         chk("err_cnt", err_cnt, m_err);
`else
         chk("and_cnt_tied", and_cnt, 16'h0);
         chk("or_cnt_tied",  or_cnt,  16'h0);
         chk("err_cnt_tied", err_cnt, 16'h0);
`endif
         if (in_valid && in_ready) acc_q.push_back(cyc);
         if (out_valid) begin
            chk("in_ready_low_in_done", in_ready, 1'b0);
            if (sb_q.size() == 0) begin
               fail_now("unexpected_out_valid");
            end else begin
               chk("op_code", op_code, sb_q[0]);
               chk("x_rec", x_rec, (sb_q[0] == C_AND) || (sb_q[0] == C_AMBIG));
               chk("err", err, (sb_q[0] == C_NONE));
               if (!r_prev_ov) begin
                  if (acc_q.size() == 0) fail_now("out_valid_without_accept");
                  else chk("latency", cyc - acc_q.pop_front(), 2);
               end
               if (out_ready) begin
                  case (sb_q[0])
                     C_AND, C_AMBIG: m_and = inc16(m_and);
                     C_OR:           m_or  = inc16(m_or);
                     default:        m_err = inc16(m_err);
                  endcase
                  void'(sb_q.pop_front());
               end
            end
         end
         if (stats_clr) begin
            m_and = 16'h0; m_or = 16'h0; m_err = 16'h0;
         end
         r_prev_ov = out_valid && !out_ready;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vr,
                       input logic [1:0] eop);
      int n = 0;
      while (!in_ready && n < 50) begin step(); n++; end
      if (!in_ready) begin
         fail_now("in_ready_timeout");
         return;
      end
      a = va; b = vb; result = vr; in_valid = 1'b1;
      sb_q.push_back(eop);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_ov();
      int n = 0;
      while (!out_valid && n < 50) begin step(); n++; end
      if (!out_valid) fail_now("out_valid_timeout");
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin step(); n++; end
      if (sb_q.size() != 0) fail_now("drain_timeout");
      step();
   endtask

   initial begin
      #3;
      chk("rst_in_ready",  in_ready,  1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_op_code",   op_code,   2'b00);
      chk("rst_x_rec",     x_rec,     1'b0);
      chk("rst_err",       err,       1'b0);
      chk("rst_and_cnt",   and_cnt,   16'h0);
      step();
      step();
      rst_n = 1'b1;
      chk("in_ready_before_edge", in_ready, 1'b0);
      step();
      chk("in_ready_after_release", in_ready, 1'b1);

      out_ready = 1'b1;
      send(8'hF0, 8'h3C, 8'h30, C_AND);
      drain();
      send(8'hF0, 8'h3C, 8'hFC, C_OR);
      send(8'h5A, 8'h5A, 8'h5A, C_AMBIG);
      drain();

      // NONE result held while the consumer stalls; stray in_valid must be ignored.
      out_ready = 1'b0;
      send(8'hF0, 8'h3C, 8'h00, C_NONE);
      wait_ov();
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         a = 8'hFF; b = 8'h00; result = 8'h00;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      send(8'h00, 8'h00, 8'h00, C_AMBIG);
      send(8'hFF, 8'h00, 8'h00, C_AND);
      send(8'hFF, 8'h00, 8'hFF, C_OR);
      send(8'hA5, 8'h5A, 8'hFF, C_OR);
      send(8'hA5, 8'h5A, 8'h00, C_AND);
      send(8'h12, 8'h34, 8'h56, C_NONE);
      send(8'h0F, 8'hF0, 8'h0F, C_NONE);
      send(8'h81, 8'h01, 8'h81, C_OR);
      drain();

`ifdef BITOP_DEC_STATS_EN
      dut.r_and_cnt <= 16'hFFFE;
      m_and = 16'hFFFE;
      step();
      send(8'hF0, 8'h3C, 8'h30, C_AND);
      send(8'h81, 8'h01, 8'h01, C_AND);
      drain();
      chk("and_cnt_saturated", and_cnt, 16'hFFFF);
      out_ready = 1'b0;
      send(8'hFF, 8'h00, 8'h00, C_AND);
      wait_ov();
      stats_clr = 1'b1;
      out_ready = 1'b1;
      step();
      stats_clr = 1'b0;
      chk("and_cnt_clr_beats_inc", and_cnt, 16'h0);
      chk("or_cnt_cleared", or_cnt, 16'h0);
`endif

      // Reset while a classification is pending in DONE.
      out_ready = 1'b0;
      send(8'hF0, 8'h3C, 8'hFC, C_OR);
      wait_ov();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready",  in_ready,  1'b0);
      chk("midrst_op_code",   op_code,   2'b00);
      chk("midrst_and_cnt",   and_cnt,   16'h0);
      chk("midrst_or_cnt",    or_cnt,    16'h0);
      chk("midrst_err_cnt",   err_cnt,   16'h0);
      sb_q.delete();
      acc_q.delete();
      step();
      rst_n = 1'b1;
      chk("midrst_in_ready_pre_edge", in_ready, 1'b0);
      step();
      chk("midrst_in_ready_post_edge", in_ready, 1'b1);

      out_ready = 1'b1;
      send(8'h12, 8'h34, 8'h56, C_NONE);
      drain();
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/bitop_decoder.md
BITOP_DECODER -- requirements
Module: bitop_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: an observation triple is presented.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts a triple this cycle.
REQ-005 SHALL have ports a and b, input, 8 bits each: the operands.
REQ-006 SHALL have port result, input, 8 bits: the observed selector output.
REQ-007 SHALL have port out_valid, output, 1 bit: a classification is held.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer takes the classification.
REQ-009 SHALL have port op_code, output, 2 bits: 00 NONE, 01 AND, 10 OR, 11 AMBIG.
REQ-010 SHALL have port x_rec, output, 1 bit: the recovered select (1 = AND path, 0 = OR path).
REQ-011 SHALL have port err, output, 1 bit: set when op_code is NONE.
REQ-012 SHALL have port stats_clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-013 SHALL have ports and_cnt, or_cnt and err_cnt, output, 16 bits each: the statistics counters.

Function
REQ-014 SHALL implement the FSM IDLE -> CAPT -> DONE -> IDLE.
REQ-015 SHALL assert in_ready only in IDLE; an in_valid&&in_ready transfer registers a, b and result and moves to CAPT.
REQ-016 SHALL, in CAPT, classify the registered triple and move to DONE, asserting out_valid on the next cycle; latency from accept to out_valid is exactly 2 cycles.
REQ-017 SHALL classify as follows:
- result==(a&b) and result==(a|b) gives AMBIG (this occurs only when a==b).
- result==(a&b) only gives AND.
- result==(a|b) only gives OR.
- otherwise gives NONE.
REQ-018 SHALL set x_rec=1 for AND and AMBIG, and x_rec=0 for OR and NONE.
REQ-019 SHALL set err=1 iff op_code is NONE.
REQ-020 SHALL, in DONE, hold op_code, x_rec, err and out_valid stable until out_valid&&out_ready, then return to IDLE; in_ready rises the cycle after the handshake.
REQ-021 SHALL ignore in_valid outside IDLE; no triple is lost, because in_ready is low in CAPT and DONE.
REQ-022 SHALL give a peak throughput of one triple per 3 cycles when out_ready is held high.
REQ-023 SHALL count each classification once, on its out_valid&&out_ready handshake:
- AND and AMBIG increment and_cnt.
- OR increments or_cnt.
- NONE increments err_cnt.
REQ-024 SHALL saturate every counter at 16'hFFFF, with no wrap-around.
REQ-025 SHALL give stats_clr priority over a simultaneous increment: the counter reads 0 on the next cycle.
REQ-026 SHALL register op_code, x_rec and err; there is no combinational path from any input to any output except in_ready, which depends on state only.

Reset
REQ-027 SHALL, while rst_n is low, force state=IDLE, in_ready=0, out_valid=0, op_code=00, x_rec=0, err=0 and all counters=0, independent of clk.
REQ-028 SHALL set in_ready=1 on the first clk edge after rst_n deasserts.
REQ-029 SHALL, when reset asserts mid-operation (CAPT or DONE), discard the pending triple with no counter update.

Configuration
REQ-030 SHALL, with BITOP_DEC_STATS_EN defined, implement and_cnt, or_cnt, err_cnt and stats_clr per REQ-023 to REQ-025.
REQ-031 SHALL, without BITOP_DEC_STATS_EN, keep all ports, tie the counter outputs to 0, ignore stats_clr and synthesize no counter flops.

Structure
REQ-032 SHALL place in shared package bitop_dec_pkg:
- the op-code enum (NONE, AND, OR, AMBIG);
- the FSM state enum;
- data width 8;
- counter width 16.
REQ-033 SHALL put the combinational classifier of REQ-017 in sub-module bitop_classify, with inputs a, b, result and output op_code.

Verification
REQ-034 SHALL cover this scenario: a=F0, b=3C, result=30, out_ready=1 -> op_code=01, x_rec=1, err=0; out_valid exactly 2 cycles after accept; and_cnt=1.
REQ-035 SHALL cover this scenario: a=F0, b=3C, result=FC -> op_code=10, x_rec=0, or_cnt=1; then a=5A, b=5A, result=5A -> op_code=11, x_rec=1, and_cnt increments.
REQ-036 SHALL cover this scenario: a=F0, b=3C, result=00 -> op_code=00, err=1, err_cnt=1; out_ready held low for 5 cycles -> outputs stable, in_ready=0, in_valid pulses ignored.
REQ-037 SHALL cover this scenario: and_cnt preloaded to FFFE by 2 AND transactions past the edge -> reads FFFF and stays there; stats_clr on the same cycle as a handshake -> counter reads 0.
REQ-038 SHALL cover this scenario: rst_n pulsed low while in DONE -> out_valid=0 immediately (asynchronously), counters=0, in_ready=1 one edge after release.
REQ-039 SHALL cover this scenario: build without BITOP_DEC_STATS_EN, 10 mixed transactions -> all counters remain 0 while classifications match REQ-017.
